control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Datapath controller: steps through a fixed microprogram and issues one 4-bit
//  control code F per step. F feeds the control-word decoder, which drives the
//  X/Y/Z buffer and register enables and the ALU op. Run/Done level handshake.
//  Supports free-run mode and a single-step mode for pushbutton-driven lab use.
// PARAMETERS
//  PROG_LEN  6  number of program words executed, legal range 1..8
//  PC_W      3  program counter width; must satisfy 2**PC_W >= 8
// PORTS
//  Clock     in   1  single system clock, rising-edge
//  Resetn    in   1  asynchronous, active-low reset
//  Run       in   1  level: start/hold the program; low aborts or acknowledges
//  StepMode  in   1  1 = advance one word per Step press, 0 = one word per clock
//  Step      in   1  raw pushbutton, asynchronous to Clock
//  F         out  4  registered control code to the decoder
//  Busy      out  1  1 while in RUN or HOLD
//  Done      out  1  1 in DONE state
//  PC        out  PC_W  current program index, for debug display
// BEHAVIOUR
//  - Reset (Resetn=0, async): state=IDLE, PC=0, F=4'b0000 (NOP), Busy=0, Done=0,
//    step synchroniser flops=0. Takes effect immediately, including mid-program.
//  - Every output is registered. No combinational path from any input to any output.
//  - States: IDLE, RUN, HOLD, DONE.
//    IDLE: F=NOP, PC=0. Run=1 at edge k -> RUN; F=ROM[0] visible after edge k.
//    RUN, StepMode=0: each edge PC++ and F=ROM[PC+1]. Each word is held exactly
//      1 cycle.
//    RUN, StepMode=1: after issuing a word -> HOLD; F keeps the current word.
//    HOLD: on the edge where a Step rise is detected -> PC++, F=ROM[PC+1], back to RUN.
//      If StepMode drops to 0 while in HOLD -> resume free-run on the next edge.
//    Last word (PC==PROG_LEN-1) issued -> next advance goes to DONE: F=NOP,
//      Done=1, Busy=0.
//    DONE: hold until Run=0, then -> IDLE (Done=0, PC=0). Run staying 1 never
//      restarts the program.
//  - Abort: Run=0 in RUN or HOLD -> IDLE on the next edge. F=NOP, PC=0, Done stays 0.
//    Abort has priority over an advance in the same cycle.
//  - Step input: 2-flop synchroniser, then rising-edge detect. One press equals one
//    advance, however long the button is held.
//  - Step edges seen in IDLE, DONE, or RUN with StepMode=0 are discarded, not queued.
//  - PC never exceeds PROG_LEN-1. There is no wrap-around; the end of the program
//    always goes through DONE.
//  - Program words (index: F): 0:0001, 1:0010, 2:0110, 3:1010, 4:1001, 5:1111,
//    6:0000, 7:0000.
//  - F=0000 is the NOP code. It is only ever issued in IDLE or DONE, and never as
//    a program word when PROG_LEN<=6.
// STRUCTURE
//  - Shared package sequencer_pkg holds:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2, ST_DONE=2'd3
//    - F_NOP=4'b0000
//    - the 8 program words as localparams
//  - Sub-module control_rom: combinational, PC_W-bit address in, 4-bit word out,
//    table from the package.
//  - Top level holds the FSM, PC, step synchroniser/edge detector and output
//    registers.
// TESTING
//  1. Resetn low for 3 cycles, then high; Run=0 -> F=0000, Busy=0, Done=0, PC=0.
//     Assert Resetn mid-RUN at PC=3 -> F=0000 asynchronously.
//  2. StepMode=0, Run=1 from cycle 0 -> F=0001, 0010, 0110, 1010, 1001, 1111 on
//     cycles 1-6; cycle 7 Done=1, F=0000. Drop Run -> IDLE next cycle.
//  3. StepMode=1, Run=1 -> F=0001 held for 20 cycles with no Step. Press Step
//     (held 10 cycles) -> exactly one advance to 0010, about 3 cycles after the
//     press edge.
//  4. Abort: Run falls while F=0110 -> next cycle F=0000, PC=0, Done=0.
//     Run reasserted -> restarts at 0001.
//  5. Run held high through DONE for 10 cycles -> Done stays 1, no restart.
//     PROG_LEN=1 -> F=0001 for one cycle, then DONE.
//  6. Step pulses in IDLE, then Run=1 with StepMode=1 -> no early advance;
//     first word is 0001.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM states, NOP code, microprogram.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] F_NOP = 4'b0000;

  // Microprogram words; F_NOP is never a live program word while PROG_LEN <= 6.
  localparam logic [3:0] PROG_W0 = 4'b0001;
  localparam logic [3:0] PROG_W1 = 4'b0010;
  localparam logic [3:0] PROG_W2 = 4'b0110;
  localparam logic [3:0] PROG_W3 = 4'b1010;
  localparam logic [3:0] PROG_W4 = 4'b1001;
  localparam logic [3:0] PROG_W5 = 4'b1111;
  localparam logic [3:0] PROG_W6 = 4'b0000;
  localparam logic [3:0] PROG_W7 = 4'b0000;

  // Index -> program word; anything past the 8-entry table reads as NOP.
  function automatic logic [3:0] prog_word(input int unsigned idx);
    case (idx)
      0:       prog_word = PROG_W0;
      1:       prog_word = PROG_W1;
      2:       prog_word = PROG_W2;
      3:       prog_word = PROG_W3;
      4:       prog_word = PROG_W4;
      5:       prog_word = PROG_W5;
      6:       prog_word = PROG_W6;
      7:       prog_word = PROG_W7;
      default: prog_word = F_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_rom.sv
// Microprogram ROM: program index in, 4-bit control code out.
// Latency: combinational, zero cycles.
// Backpressure: none.
module control_rom
  import sequencer_pkg::*;
#(
  parameter int PC_W = 3
) (
  input  logic [PC_W-1:0] addr,
  output logic [3:0]      word
);

  // Pure table lookup; the sequencer registers the result.
  always_comb begin
    word = prog_word(int'(unsigned'(addr)));
  end

endmodule

// File: rtl/control_sequencer.sv
// Microprogram sequencer: issues one registered control code F per program step.
// Latency: F/PC/Busy/Done change one edge after the deciding input; Step adds ~3 edges of sync.
// Backpressure: Run is a level handshake; low aborts a program or acknowledges Done.
module control_sequencer
  import sequencer_pkg::*;
#(
  parameter int PROG_LEN = 6,  // legal 1..8
  parameter int PC_W     = 3   // 2**PC_W must cover 8 program words
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic            StepMode,
  input  logic            Step,
  output logic [3:0]      F,
  output logic            Busy,
  output logic            Done,
  output logic [PC_W-1:0] PC
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [3:0]      f_n;
  logic [PC_W-1:0] rom_addr;
  logic [3:0]      rom_word;
  logic            advance;
  logic            step_s1, step_s2, step_s3;
  logic            step_rise;

  // Step is a raw pushbutton: two flops to resynchronise, a third to find the rising edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= Step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_s3;

  // Leaving IDLE fetches word 0; every other fetch is the word after the current one.
  assign rom_addr = (state == ST_IDLE) ? '0 : PC + 1'b1;

  control_rom #(.PC_W(PC_W)) u_rom (
    .addr (rom_addr),
    .word (rom_word)
  );

  // Next state, next PC and next control code; abort outranks any advance.
  always_comb begin
    state_n = state;
    pc_n    = PC;
    f_n     = F;
    advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Run) begin
          state_n = ST_RUN;
          pc_n    = '0;
          f_n     = rom_word;
        end
      end
      ST_RUN: begin
        if (!Run) begin
          state_n = ST_IDLE;
          pc_n    = '0;
          f_n     = F_NOP;
        end else if (StepMode) begin
          state_n = ST_HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!Run) begin
          state_n = ST_IDLE;
          pc_n    = '0;
          f_n     = F_NOP;
        end else if (!StepMode || step_rise) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        if (!Run) begin
          state_n = ST_IDLE;
          pc_n    = '0;
          f_n     = F_NOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pc_n    = '0;
        f_n     = F_NOP;
      end
    endcase

    // The end of the program always lands in DONE; PC is never pushed past the last word.
    if (advance) begin
      if (PC == LAST_PC) begin
        state_n = ST_DONE;
        f_n     = F_NOP;
      end else begin
        state_n = ST_RUN;
        pc_n    = PC + 1'b1;
        f_n     = rom_word;
      end
    end
  end

  // State and all outputs are registered so no input reaches an output combinationally.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_IDLE;
      PC    <= '0;
      F     <= F_NOP;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      PC    <= pc_n;
      F     <= f_n;
      Busy  <= (state_n == ST_RUN) || (state_n == ST_HOLD);
      Done  <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random Run/StepMode/Step traffic.
// Two instances (6-word and 1-word programs) share stimulus; each has its own reference model.
// Outputs are compared 1 time unit after every rising edge.
module tb_control_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn, Run, StepMode, Step;
  logic [3:0] f0, f1;
  logic       busy0, busy1, done0, done1;
  logic [2:0] pc0, pc1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.PROG_LEN(6), .PC_W(3)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .StepMode(StepMode), .Step(Step),
    .F(f0), .Busy(busy0), .Done(done0), .PC(pc0)
  );

  control_sequencer #(.PROG_LEN(1), .PC_W(3)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .StepMode(StepMode), .Step(Step),
    .F(f1), .Busy(busy1), .Done(done1), .PC(pc1)
  );

  // Reference model: program table and per-instance view of where the program is.
  logic [3:0] prog_tbl [8] = '{4'h1, 4'h2, 4'h6, 4'hA, 4'h9, 4'hF, 4'h0, 4'h0};
  int  plen    [2] = '{6, 1};
  bit  m_active[2];   // program running (issuing words)
  bit  m_paused[2];   // waiting for a Step press
  bit  m_fin   [2];   // program finished, waiting for Run to drop
  int  m_idx   [2];
  bit  samp_q  [$];   // Step as sampled at each edge, oldest first

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_paused[i] = 0; m_fin[i] = 0; m_idx[i] = 0;
    end
    samp_q = '{0, 0, 0};
  endtask

  // One clock edge of program behaviour for instance i.
  task automatic model_edge(input int i, input bit run, input bit smode, input bit press);
    bit go;
    if (m_fin[i]) begin
      if (!run) begin m_fin[i] = 0; m_idx[i] = 0; end
    end else if (!m_active[i]) begin
      if (run) begin m_active[i] = 1; m_paused[i] = 0; m_idx[i] = 0; end
    end else if (!run) begin
      m_active[i] = 0; m_paused[i] = 0; m_idx[i] = 0;
    end else begin
      go = m_paused[i] ? (!smode || press) : !smode;
      if (!go) m_paused[i] = 1;
      else if (m_idx[i] == plen[i] - 1) begin
        m_active[i] = 0; m_paused[i] = 0; m_fin[i] = 1;
      end else begin
        m_idx[i]++; m_paused[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("F0",    32'(f0),    32'(m_active[0] ? prog_tbl[m_idx[0]] : 4'h0));
    check("BUSY0", 32'(busy0), 32'(m_active[0]));
    check("DONE0", 32'(done0), 32'(m_fin[0]));
    check("PC0",   32'(pc0),   32'(m_idx[0]));
    check("F1",    32'(f1),    32'(m_active[1] ? prog_tbl[m_idx[1]] : 4'h0));
    check("BUSY1", 32'(busy1), 32'(m_active[1]));
    check("DONE1", 32'(done1), 32'(m_fin[1]));
    check("PC1",   32'(pc1),   32'(m_idx[1]));
  endtask

  // Advance one edge: a press counts when Step was low then high two and three edges back.
  task automatic tick();
    bit press;
    @(posedge Clock);
    press = samp_q[$-1] && !samp_q[$-2];
    for (int i = 0; i < 2; i++) model_edge(i, Run, StepMode, press);
    samp_q.push_back(Step);
    if (samp_q.size() > 8) void'(samp_q.pop_front());
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int hold_left;

    // Reset for three cycles with Run low.
    Resetn = 1'b0; Run = 1'b0; StepMode = 1'b0; Step = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    model_reset();
    compare_all();
    ticks(2);

    // Free run to DONE, then drop Run.
    Run = 1'b1; StepMode = 1'b0;
    ticks(9);
    check("DONE_AFTER_FREE_RUN", 32'(done0), 32'd1);
    Run = 1'b0;
    ticks(2);

    // Single-step: no press holds word 0, one long press advances exactly once.
    StepMode = 1'b1; Run = 1'b1;
    ticks(20);
    check("HOLD_NO_STEP", 32'(f0), 32'h1);
    Step = 1'b1;
    ticks(10);
    Step = 1'b0;
    ticks(5);
    check("ONE_ADVANCE_PER_PRESS", 32'(f0), 32'h2);
    Run = 1'b0;
    ticks(2);

    // Abort while 0110 is out, then restart.
    StepMode = 1'b0; Run = 1'b1;
    ticks(3);
    check("ABORT_PRE_WORD", 32'(f0), 32'h6);
    Run = 1'b0;
    ticks(1);
    Run = 1'b1;
    ticks(1);
    check("RESTART_WORD0", 32'(f0), 32'h1);

    // Run held through DONE must not restart.
    ticks(16);
    check("DONE_NO_RESTART", 32'(done0), 32'd1);
    Run = 1'b0;
    ticks(2);

    // Presses while idle are not queued.
    for (int k = 0; k < 3; k++) begin
      Step = 1'b1; ticks(2);
      Step = 1'b0; ticks(2);
    end
    StepMode = 1'b1; Run = 1'b1;
    ticks(6);
    check("NO_EARLY_ADVANCE", 32'(f0), 32'h1);
    Run = 1'b0;
    ticks(2);

    // Randomized Run / StepMode / Step traffic.
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) Run = ~Run;
      if ($urandom_range(0, 39) == 0) StepMode = ~StepMode;
      if (hold_left == 0) begin
        Step = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 6);
      end else begin
        hold_left--;
      end
      tick();
    end
    Run = 1'b0; Step = 1'b0;
    ticks(2);

    // Asynchronous reset mid-program at PC=3.
    StepMode = 1'b0; Run = 1'b1;
    ticks(4);
    check("PC_BEFORE_ARST", 32'(pc0), 32'd3);
    #2;
    Resetn = 1'b0;
    #1;
    check("ARST_F",    32'(f0),    32'h0);
    check("ARST_PC",   32'(pc0),   32'd0);
    check("ARST_BUSY", 32'(busy0), 32'd0);
    Run = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    model_reset();
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
